retire_order_queue: RTL and testbench

Program-order tracker that feeds the reorder buffer's retire logic. At dispatch it records the issue-queue index of each instruction in program order, up to two per cycle. It presents the two oldest outstanding indices as `oldest0`/`oldest1`, and pops them when the reorder buffer asserts `retire0`/`retire1`. It is the single source of in-order commit sequencing between dispatch and the reorder buffer.

---
 rtl/retire_order_queue_pkg.sv | 12 +
 rtl/retire_order_queue_order_ram.sv | 35 +++
 rtl/retire_order_queue.sv | 119 +++++++++++
 tb/tb_retire_order_queue.sv | 214 +++++++++++++++++++++
 4 files changed

// File: rtl/retire_order_queue_pkg.sv
// Shared constants and types for the retire-order queue (dispatch/retire widths, IQ index type).
`ifndef NUM_IQ_ENTRIES_LOG2
`define NUM_IQ_ENTRIES_LOG2 4
`endif

package retire_order_queue_pkg;
   localparam int NUM_IQ_ENTRIES_LOG2 = `NUM_IQ_ENTRIES_LOG2;
   localparam int DISPATCH_W          = 2;
   localparam int RETIRE_W            = 2;

   typedef logic [NUM_IQ_ENTRIES_LOG2-1:0] iq_idx_t;
endpackage

// File: rtl/retire_order_queue_order_ram.sv
// Program-order index storage: DISPATCH_W sync write ports (higher port wins), RETIRE_W async reads, sync clear.
module order_ram
   import retire_order_queue_pkg::*;
#(
   parameter int IDX_WIDTH  = 4,
   parameter int DEPTH_LOG2 = 5,
   parameter int DEPTH      = 1 << DEPTH_LOG2
) (
   input  logic                                          clk,
   input  logic                                          clear,
   input  logic [DISPATCH_W-1:0]                         we,
   input  logic [DISPATCH_W-1:0][DEPTH_LOG2-1:0]         waddr,
   input  logic [DISPATCH_W-1:0][IDX_WIDTH-1:0]          wdata,
   input  logic [RETIRE_W-1:0][DEPTH_LOG2-1:0]           raddr,
   output logic [RETIRE_W-1:0][IDX_WIDTH-1:0]            rdata
);

   logic [IDX_WIDTH-1:0] mem [DEPTH];

   // Later ports overwrite earlier ones on a shared address.
   always_ff @(posedge clk) begin
      if (clear) begin
         for (int s = 0; s < DEPTH; s++) mem[s] <= '0;
      end else begin
         for (int i = 0; i < DISPATCH_W; i++) begin
            if (we[i]) mem[waddr[i]] <= wdata[i];
         end
      end
   end

   for (genvar r = 0; r < RETIRE_W; r++) begin : g_rd
      assign rdata[r] = mem[raddr[r]];
   end

endmodule

// File: rtl/retire_order_queue.sv
// In-order dispatch-to-retire index queue, two pushes and two pops per cycle.
// Optional RETIRE_ORDER_QUEUE_FLUSH_EN adds a flush port that empties the queue without touching overflow.
`ifndef NUM_IQ_ENTRIES_LOG2
`define NUM_IQ_ENTRIES_LOG2 4
`endif

module retire_order_queue
   import retire_order_queue_pkg::*;
#(
   parameter int IDX_WIDTH  = `NUM_IQ_ENTRIES_LOG2,
   parameter int DEPTH_LOG2 = 5,
   parameter int DEPTH      = 1 << DEPTH_LOG2
) (
   input  logic                  clk,
   input  logic                  reset,
`ifdef RETIRE_ORDER_QUEUE_FLUSH_EN
   input  logic                  flush,
`endif
   input  logic                  dispatch0,
   input  logic [IDX_WIDTH-1:0]  dispatch_index0,
   input  logic                  dispatch1,
   input  logic [IDX_WIDTH-1:0]  dispatch_index1,
   input  logic                  retire0,
   input  logic                  retire1,
   output logic [IDX_WIDTH-1:0]  oldest0,
   output logic [IDX_WIDTH-1:0]  oldest1,
   output logic                  oldest_vld0,
   output logic                  oldest_vld1,
   output logic [DEPTH_LOG2:0]   count,
   output logic                  empty,
   output logic                  full,
   output logic                  almost_full,
   output logic                  overflow
);

   localparam int CW = DEPTH_LOG2 + 1;

   logic [DEPTH_LOG2-1:0] head, tail;
   logic [CW-1:0]         cnt, free;
   logic                  ovf, flush_i;
   logic                  acc0, acc1, pop0, pop1, drop;
   logic [1:0]            n_push, n_pop;

`ifdef RETIRE_ORDER_QUEUE_FLUSH_EN
   assign flush_i = flush;
`else
   assign flush_i = 1'b0;
`endif

   // Room comes only from the registered count; same-cycle pops never make space.
   assign free = CW'(DEPTH) - cnt;
   assign acc0 = dispatch0 && !flush_i && (free != '0);
   assign acc1 = dispatch1 && !flush_i && (free >= (acc0 ? CW'(2) : CW'(1)));
   assign drop = !flush_i && ((dispatch0 && !acc0) || (dispatch1 && !acc1));

   assign pop0 = retire0 && oldest_vld0 && !flush_i;
   assign pop1 = retire1 && pop0 && oldest_vld1;

   assign n_push = {1'b0, acc0} + {1'b0, acc1};
   assign n_pop  = {1'b0, pop0} + {1'b0, pop1};

   always_ff @(posedge clk) begin
      if (reset) begin
         head <= '0;
         tail <= '0;
         cnt  <= '0;
         ovf  <= 1'b0;
      end else if (flush_i) begin
         head <= '0;
         tail <= '0;
         cnt  <= '0;
      end else begin
         head <= head + DEPTH_LOG2'(n_pop);
         tail <= tail + DEPTH_LOG2'(n_push);
         cnt  <= cnt + CW'(n_push) - CW'(n_pop);
         if (drop) ovf <= 1'b1;
      end
   end

   logic [DISPATCH_W-1:0]                 we;
   logic [DISPATCH_W-1:0][DEPTH_LOG2-1:0] waddr;
   logic [DISPATCH_W-1:0][IDX_WIDTH-1:0]  wdata;
   logic [RETIRE_W-1:0][DEPTH_LOG2-1:0]   raddr;
   logic [RETIRE_W-1:0][IDX_WIDTH-1:0]    rdata;

   // Compaction: a lone dispatch1 lands at tail, so ports never collide.
   assign we       = {acc1, acc0};
   assign waddr[0] = tail;
   assign waddr[1] = tail + DEPTH_LOG2'(acc0);
   assign wdata[0] = dispatch_index0;
   assign wdata[1] = dispatch_index1;
   assign raddr[0] = head;
   assign raddr[1] = head + DEPTH_LOG2'(1);

   order_ram #(
      .IDX_WIDTH  (IDX_WIDTH),
      .DEPTH_LOG2 (DEPTH_LOG2),
      .DEPTH      (DEPTH)
   ) u_ram (
      .clk   (clk),
      .clear (reset),
      .we    (we),
      .waddr (waddr),
      .wdata (wdata),
      .raddr (raddr),
      .rdata (rdata)
   );

   assign oldest0     = rdata[0];
   assign oldest1     = rdata[1];
   assign oldest_vld0 = (cnt != '0);
   assign oldest_vld1 = (cnt >= CW'(2));
   assign count       = cnt;
   assign empty       = (cnt == '0);
   assign full        = (cnt == CW'(DEPTH));
   assign almost_full = (free < CW'(2));
   assign overflow    = ovf;

endmodule

// File: tb/tb_retire_order_queue.sv
// Bench for retire_order_queue: directed scenarios plus randomized traffic against a queue-based model.
module tb_retire_order_queue;
   localparam int IW    = 4;
   localparam int DL2   = 5;
   localparam int DEPTH = 32;

   logic          clk = 1'b0;
   logic          rst = 1'b0, fl = 1'b0;
   logic          d0 = 1'b0, d1 = 1'b0, r0 = 1'b0, r1 = 1'b0;
   logic [IW-1:0] i0 = '0, i1 = '0;
   logic [IW-1:0] oldest0, oldest1;
   logic          oldest_vld0, oldest_vld1, empty, full, almost_full, overflow;
   logic [DL2:0]  count;

   int checks = 0;
   int errors = 0;

   logic [IW-1:0] mq[$];
   logic          movf = 1'b0;

   always #5 clk = ~clk;

   retire_order_queue #(.IDX_WIDTH(IW), .DEPTH_LOG2(DL2), .DEPTH(DEPTH)) dut (
      .clk             (clk),
      .reset           (rst),
`ifdef RETIRE_ORDER_QUEUE_FLUSH_EN
      .flush           (fl),
`endif
      .dispatch0       (d0),
      .dispatch_index0 (i0),
      .dispatch1       (d1),
      .dispatch_index1 (i1),
      .retire0         (r0),
      .retire1         (r1),
      .oldest0         (oldest0),
      .oldest1         (oldest1),
      .oldest_vld0     (oldest_vld0),
      .oldest_vld1     (oldest_vld1),
      .count           (count),
      .empty           (empty),
      .full            (full),
      .almost_full     (almost_full),
      .overflow        (overflow)
   );

   // One clock: apply inputs, advance the reference queue from the pre-edge state, sample 1 time unit after the edge.
   task automatic cycle(input logic a_d0, input logic [IW-1:0] a_i0, input logic a_d1, input logic [IW-1:0] a_i1,
                        input logic a_r0, input logic a_r1, input logic a_rst, input logic a_fl);
      int sz, fr;
      logic a0, a1, p0, p1;
      d0 = a_d0; i0 = a_i0; d1 = a_d1; i1 = a_i1; r0 = a_r0; r1 = a_r1; rst = a_rst; fl = a_fl;
      if (a_rst) begin
         mq.delete(); movf = 1'b0;
      end else if (a_fl) begin
         mq.delete();
      end else begin
         sz = mq.size(); fr = DEPTH - sz;
         a0 = a_d0 && fr >= 1;
         a1 = a_d1 && fr >= (a0 ? 2 : 1);
         p0 = a_r0 && sz >= 1;
         p1 = a_r1 && p0 && sz >= 2;
         if (p0) void'(mq.pop_front());
         if (p1) void'(mq.pop_front());
         if (a0) mq.push_back(a_i0);
         if (a1) mq.push_back(a_i1);
         if ((a_d0 && !a0) || (a_d1 && !a1)) movf = 1'b1;
      end
      @(posedge clk);
      #1;
      d0 = 0; d1 = 0; r0 = 0; r1 = 0; rst = 0; fl = 0;
   endtask

   task automatic test_reset();
      cycle(0, 0, 0, 0, 0, 0, 1, 0);
      cycle(0, 0, 0, 0, 0, 0, 1, 0);
      checks++; if (count !== 6'd0) begin errors++; $display("FAIL reset_count got %0d want 0", count); end
      checks++; if (empty !== 1'b1) begin errors++; $display("FAIL reset_empty got %b want 1", empty); end
      checks++; if (full !== 1'b0 || almost_full !== 1'b0) begin errors++; $display("FAIL reset_full got %b/%b want 0/0", full, almost_full); end
      checks++; if (oldest_vld0 !== 1'b0 || oldest_vld1 !== 1'b0) begin errors++; $display("FAIL reset_vld got %b%b want 00", oldest_vld0, oldest_vld1); end
      checks++; if (oldest0 !== 4'd0 || oldest1 !== 4'd0) begin errors++; $display("FAIL reset_oldest got %0d/%0d want 0/0", oldest0, oldest1); end
      checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL reset_overflow got %b want 0", overflow); end
   endtask

   task automatic test_dual_push();
      cycle(1, 4'd3, 1, 4'd7, 0, 0, 0, 0);
      checks++; if (oldest0 !== 4'd3 || oldest1 !== 4'd7) begin errors++; $display("FAIL dual_oldest got %0d/%0d want 3/7", oldest0, oldest1); end
      checks++; if (oldest_vld0 !== 1'b1 || oldest_vld1 !== 1'b1) begin errors++; $display("FAIL dual_vld got %b%b want 11", oldest_vld0, oldest_vld1); end
      checks++; if (count !== 6'd2) begin errors++; $display("FAIL dual_count got %0d want 2", count); end
      cycle(0, 0, 0, 0, 1, 1, 0, 0);
      checks++; if (count !== 6'd0 || empty !== 1'b1) begin errors++; $display("FAIL dual_pop got count %0d empty %b want 0/1", count, empty); end
   endtask

   task automatic test_lone_dispatch1();
      cycle(0, 0, 1, 4'd9, 0, 0, 0, 0);
      checks++; if (oldest0 !== 4'd9 || oldest_vld0 !== 1'b1) begin errors++; $display("FAIL lone_oldest0 got %0d vld %b want 9/1", oldest0, oldest_vld0); end
      checks++; if (oldest_vld1 !== 1'b0) begin errors++; $display("FAIL lone_vld1 got %b want 0", oldest_vld1); end
      cycle(0, 0, 0, 0, 1, 1, 0, 0);
      checks++; if (count !== 6'd0 || empty !== 1'b1) begin errors++; $display("FAIL lone_pop got count %0d empty %b want 0/1", count, empty); end
      // retire1 alone must not pop
      cycle(1, 4'd2, 0, 0, 0, 0, 0, 0);
      cycle(0, 0, 0, 0, 0, 1, 0, 0);
      checks++; if (count !== 6'd1 || oldest0 !== 4'd2) begin errors++; $display("FAIL retire1_only got count %0d oldest0 %0d want 1/2", count, oldest0); end
      cycle(0, 0, 0, 0, 1, 0, 0, 0);
   endtask

   task automatic test_empty_push_pop();
      cycle(1, 4'd5, 0, 0, 1, 1, 0, 0);
      checks++; if (count !== 6'd1 || oldest0 !== 4'd5) begin errors++; $display("FAIL empty_pushpop got count %0d oldest0 %0d want 1/5", count, oldest0); end
      cycle(0, 0, 0, 0, 1, 0, 0, 0);
      checks++; if (empty !== 1'b1) begin errors++; $display("FAIL empty_pushpop_drain got empty %b want 1", empty); end
   endtask

   task automatic test_full();
      cycle(0, 0, 0, 0, 0, 0, 1, 0);
      for (int k = 0; k < 15; k++) cycle(1, 4'(2*k+1), 1, 4'(2*k+2), 0, 0, 0, 0);
      cycle(1, 4'(31), 0, 0, 0, 0, 0, 0);
      checks++; if (count !== 6'd31 || almost_full !== 1'b1 || full !== 1'b0) begin errors++; $display("FAIL fill31 got count %0d af %b full %b want 31/1/0", count, almost_full, full); end
      checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL fill31_ovf got %b want 0", overflow); end
      cycle(1, 4'd10, 1, 4'd11, 0, 0, 0, 0);
      checks++; if (count !== 6'd32 || full !== 1'b1) begin errors++; $display("FAIL full_count got %0d full %b want 32/1", count, full); end
      checks++; if (overflow !== 1'b1) begin errors++; $display("FAIL full_ovf got %b want 1", overflow); end
      checks++; if (oldest0 !== 4'd1 || oldest1 !== 4'd2) begin errors++; $display("FAIL full_oldest got %0d/%0d want 1/2", oldest0, oldest1); end
      cycle(1, 4'd12, 1, 4'd13, 1, 1, 0, 0);
      checks++; if (count !== 6'd30 || full !== 1'b0) begin errors++; $display("FAIL full_pushpop got count %0d full %b want 30/0", count, full); end
      checks++; if (oldest0 !== 4'd3 || oldest1 !== 4'd4) begin errors++; $display("FAIL full_pushpop_oldest got %0d/%0d want 3/4", oldest0, oldest1); end
      checks++; if (overflow !== 1'b1) begin errors++; $display("FAIL ovf_sticky got %b want 1", overflow); end
   endtask

   task automatic test_reset_mid();
      for (int k = 0; k < 10; k++) cycle(0, 0, 0, 0, 1, 1, 0, 0);
      checks++; if (count !== 6'd10) begin errors++; $display("FAIL mid_pre_count got %0d want 10", count); end
      cycle(1, 4'd4, 1, 4'd5, 1, 1, 1, 0);
      checks++; if (count !== 6'd0 || empty !== 1'b1 || full !== 1'b0 || almost_full !== 1'b0) begin errors++; $display("FAIL mid_reset_flags got count %0d e%b f%b af%b want 0/1/0/0", count, empty, full, almost_full); end
      checks++; if (oldest0 !== 4'd0 || oldest1 !== 4'd0 || oldest_vld0 !== 1'b0 || oldest_vld1 !== 1'b0) begin errors++; $display("FAIL mid_reset_oldest got %0d/%0d vld %b%b want 0/0 00", oldest0, oldest1, oldest_vld0, oldest_vld1); end
      checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL mid_reset_ovf got %b want 0", overflow); end
   endtask

   task automatic test_wrap();
      cycle(0, 0, 0, 0, 0, 0, 1, 0);
      for (int k = 0; k < 15; k++) begin
         cycle(1, 4'(k), 1, 4'(k+1), 0, 0, 0, 0);
         cycle(0, 0, 0, 0, 1, 1, 0, 0);
      end
      cycle(1, 4'd1, 0, 0, 0, 0, 0, 0);
      cycle(0, 0, 0, 0, 1, 0, 0, 0);
      cycle(1, 4'd12, 1, 4'd13, 0, 0, 0, 0);
      checks++; if (oldest0 !== 4'd12 || oldest1 !== 4'd13 || oldest_vld1 !== 1'b1) begin errors++; $display("FAIL wrap_oldest got %0d/%0d vld1 %b want 12/13/1", oldest0, oldest1, oldest_vld1); end
      cycle(0, 0, 0, 0, 1, 1, 0, 0);
      cycle(1, 4'd5, 1, 4'd6, 0, 0, 0, 0);
      checks++; if (oldest0 !== 4'd5 || oldest1 !== 4'd6 || count !== 6'd2) begin errors++; $display("FAIL wrap_after got %0d/%0d count %0d want 5/6/2", oldest0, oldest1, count); end
   endtask

   task automatic test_random();
      logic rd0, rd1, rr0, rr1, rrst, rfl;
      cycle(0, 0, 0, 0, 0, 0, 1, 0);
      for (int k = 0; k < 3000; k++) begin
         if (((k / 250) % 2) == 0) begin
            rd0 = ($urandom_range(0, 3) != 0); rd1 = ($urandom_range(0, 3) != 0);
            rr0 = ($urandom_range(0, 3) == 0); rr1 = $urandom_range(0, 1) == 1;
         end else begin
            rd0 = ($urandom_range(0, 3) == 0); rd1 = $urandom_range(0, 1) == 1;
            rr0 = ($urandom_range(0, 3) != 0); rr1 = $urandom_range(0, 1) == 1;
         end
         rrst = ($urandom_range(0, 399) == 0);
`ifdef RETIRE_ORDER_QUEUE_FLUSH_EN
         rfl = ($urandom_range(0, 199) == 0);
`else
         rfl = 1'b0;
`endif
         cycle(rd0, 4'($urandom), rd1, 4'($urandom), rr0, rr1, rrst, rfl);
         checks++; if (count !== 6'(mq.size())) begin errors++; $display("FAIL rnd_count cyc %0d got %0d want %0d", k, count, mq.size()); end
         checks++; if (empty !== (mq.size() == 0) || full !== (mq.size() == DEPTH) || almost_full !== (mq.size() >= DEPTH-1)) begin errors++; $display("FAIL rnd_flags cyc %0d got e%b f%b af%b size %0d", k, empty, full, almost_full, mq.size()); end
         checks++; if (oldest_vld0 !== (mq.size() >= 1) || oldest_vld1 !== (mq.size() >= 2)) begin errors++; $display("FAIL rnd_vld cyc %0d got %b%b size %0d", k, oldest_vld0, oldest_vld1, mq.size()); end
         checks++; if (overflow !== movf) begin errors++; $display("FAIL rnd_ovf cyc %0d got %b want %b", k, overflow, movf); end
         if (mq.size() >= 1) begin
            checks++; if (oldest0 !== mq[0]) begin errors++; $display("FAIL rnd_oldest0 cyc %0d got %0d want %0d", k, oldest0, mq[0]); end
         end
         if (mq.size() >= 2) begin
            checks++; if (oldest1 !== mq[1]) begin errors++; $display("FAIL rnd_oldest1 cyc %0d got %0d want %0d", k, oldest1, mq[1]); end
         end
      end
   endtask

`ifdef RETIRE_ORDER_QUEUE_FLUSH_EN
   task automatic test_flush();
      cycle(0, 0, 0, 0, 0, 0, 1, 0);
      for (int k = 0; k < 17; k++) cycle(1, 4'(k), 1, 4'(k+3), 0, 0, 0, 0);
      for (int k = 0; k < 13; k++) cycle(0, 0, 0, 0, 1, 1, 0, 0);
      cycle(0, 0, 0, 0, 1, 0, 0, 0);
      checks++; if (count !== 6'd5 || overflow !== 1'b1) begin errors++; $display("FAIL flush_pre got count %0d ovf %b want 5/1", count, overflow); end
      cycle(1, 4'd2, 1, 4'd3, 1, 1, 0, 1);
      checks++; if (count !== 6'd0 || empty !== 1'b1) begin errors++; $display("FAIL flush_count got %0d empty %b want 0/1", count, empty); end
      checks++; if (overflow !== 1'b1) begin errors++; $display("FAIL flush_ovf got %b want 1", overflow); end
      cycle(1, 4'd8, 0, 0, 0, 0, 0, 0);
      checks++; if (count !== 6'd1 || oldest0 !== 4'd8) begin errors++; $display("FAIL flush_after got count %0d oldest0 %0d want 1/8", count, oldest0); end
   endtask
`endif

   initial begin
      test_reset();
      test_dual_push();
      test_lone_dispatch1();
      test_empty_push_pop();
      test_full();
      test_reset_mid();
      test_wrap();
`ifdef RETIRE_ORDER_QUEUE_FLUSH_EN
      test_flush();
`endif
      test_random();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
